// File: rtl/eds_post_processor.sv
// EDS line-sensor post processor.
// Samples the slow sensor interface in the clk_i domain. Reorders the eight
// 16-bit lanes into natural pixel order and emits each accepted word as two
// 64-bit beats. Flags words that hold any pixel outside the 12-bit range.
// Ports:
//   clk_i, rst_i             system clock, async active-low reset
//   eds_clk_i                sensor clock, sampled as data
//   eds_frame_en_i           frame active
//   eds_sensor_data_en_i     word valid
//   eds_sensor_data_i[127:0] eight 16-bit lanes, lane k at [16k+15:16k]
//   eds_post_vld_o           one-cycle strobe per output beat
//   eds_post_data_o[63:0]    four pixels, lowest index in [15:0]
//   eds_error_cnt_o[31:0]    erroneous words in the current frame (saturating)
//   eds_error_vld_o          one-cycle error strobe, coincident with beat A
//   eds_error_data_o[15:0]   lowest-index offending pixel
module eds_post_processor (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         eds_clk_i,
  input  logic         eds_frame_en_i,
  input  logic         eds_sensor_data_en_i,
  input  logic [127:0] eds_sensor_data_i,
  output logic         eds_post_vld_o,
  output logic [63:0]  eds_post_data_o,
  output logic [31:0]  eds_error_cnt_o,
  output logic         eds_error_vld_o,
  output logic [15:0]  eds_error_data_o
);

  localparam int unsigned PIX_W   = 16;
  localparam int unsigned NUM_PIX = 8;
  localparam int unsigned WORD_W  = 128;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned CNT_W   = 32;
  // Source lane of pixels P1..P8
  localparam int unsigned LANE_MAP [NUM_PIX] = '{4, 6, 5, 0, 7, 2, 1, 3};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEAT_A = 2'd1,
    BEAT_B = 2'd2
  } state_e;

  logic [2:0]        clk_sync_q;
  logic [2:0]        fen_sync_q;
  logic [1:0]        den_sync_q;
  logic              rise_q;
  logic [WORD_W-1:0] cap_data_q;
  logic              cap_accept_q;

  state_e            state_q, state_d;
  logic              post_vld_q, post_vld_d;
  logic [BEAT_W-1:0] post_data_q, post_data_d;
  logic              err_vld_q, err_vld_d;
  logic [PIX_W-1:0]  err_data_q, err_data_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [PIX_W-1:0]  pix [NUM_PIX];
  logic [BEAT_W-1:0] beat_a, beat_b;
  logic              word_err;
  logic [PIX_W-1:0]  err_pix;
  logic              frame_rise;

  // Synchronizers, sensor-edge strobe and word capture
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      clk_sync_q   <= '0;
      fen_sync_q   <= '0;
      den_sync_q   <= '0;
      rise_q       <= 1'b0;
      cap_data_q   <= '0;
      cap_accept_q <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], eds_clk_i};
      fen_sync_q   <= {fen_sync_q[1:0], eds_frame_en_i};
      den_sync_q   <= {den_sync_q[0], eds_sensor_data_en_i};
      rise_q       <= clk_sync_q[1] & ~clk_sync_q[2];
      cap_accept_q <= rise_q & fen_sync_q[1] & den_sync_q[1];
      if (rise_q) begin
        cap_data_q <= eds_sensor_data_i;
      end
    end
  end

  // Lane-to-pixel reorder
  for (genvar g = 0; g < NUM_PIX; g++) begin : g_pix
    assign pix[g] = cap_data_q[PIX_W*LANE_MAP[g] +: PIX_W];
  end

  assign beat_a = {pix[3], pix[2], pix[1], pix[0]};
  assign beat_b = {pix[7], pix[6], pix[5], pix[4]};

  // Range check; descending scan leaves the lowest-index offender in err_pix
  always_comb begin
    word_err = 1'b0;
    err_pix  = '0;
    for (int i = NUM_PIX - 1; i >= 0; i--) begin
      if (pix[3'(i)][PIX_W-1:12] != '0) begin
        word_err = 1'b1;
        err_pix  = pix[3'(i)];
      end
    end
  end

  assign frame_rise = fen_sync_q[1] & ~fen_sync_q[2];

  // Beat sequencer: next state and registered-output next values
  always_comb begin
    state_d     = state_q;
    post_vld_d  = 1'b0;
    post_data_d = post_data_q;
    err_vld_d   = 1'b0;
    err_data_d  = err_data_q;
    case (state_q)
      IDLE: begin
        if (cap_accept_q) begin
          state_d     = BEAT_A;
          post_vld_d  = 1'b1;
          post_data_d = beat_a;
          if (word_err) begin
            err_vld_d  = 1'b1;
            err_data_d = err_pix;
          end
        end
      end
      BEAT_A: begin
        state_d     = BEAT_B;
        post_vld_d  = 1'b1;
        post_data_d = beat_b;
      end
      BEAT_B:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error counter: frame-start clear wins, but a coincident error still counts
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_rise) begin
      err_cnt_d = err_vld_q ? CNT_W'(1) : '0;
    end else if (err_vld_q && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      post_vld_q  <= 1'b0;
      post_data_q <= '0;
      err_vld_q   <= 1'b0;
      err_data_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      post_vld_q  <= post_vld_d;
      post_data_q <= post_data_d;
      err_vld_q   <= err_vld_d;
      err_data_q  <= err_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign eds_post_vld_o   = post_vld_q;
  assign eds_post_data_o  = post_data_q;
  assign eds_error_vld_o  = err_vld_q;
  assign eds_error_data_o = err_data_q;
  assign eds_error_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_eds_post_processor.sv
// Randomized scoreboard bench for eds_post_processor.
module tb_eds_post_processor;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         eds_clk_i;
  logic         eds_frame_en_i;
  logic         eds_sensor_data_en_i;
  logic [127:0] eds_sensor_data_i;
  logic         eds_post_vld_o;
  logic [63:0]  eds_post_data_o;
  logic [31:0]  eds_error_cnt_o;
  logic         eds_error_vld_o;
  logic [15:0]  eds_error_data_o;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_beats [$];
  logic [15:0] exp_errs  [$];
  logic [31:0] mdl_cnt;
  bit          mdl_fe_prev;
  int          lane_of [8] = '{4, 6, 5, 0, 7, 2, 1, 3};

  eds_post_processor dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .eds_clk_i            (eds_clk_i),
    .eds_frame_en_i       (eds_frame_en_i),
    .eds_sensor_data_en_i (eds_sensor_data_en_i),
    .eds_sensor_data_i    (eds_sensor_data_i),
    .eds_post_vld_o       (eds_post_vld_o),
    .eds_post_data_o      (eds_post_data_o),
    .eds_error_cnt_o      (eds_error_cnt_o),
    .eds_error_vld_o      (eds_error_vld_o),
    .eds_error_data_o     (eds_error_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected beats, error pixel and counter for one sensor word
  task automatic model_word(input logic [127:0] d, input bit fe, input bit de);
    logic [15:0] p [8];
    logic [63:0] a, b;
    bit          found;
    for (int i = 0; i < 8; i++) p[i] = 16'((d >> (16 * lane_of[i])) & 128'hFFFF);
    if (fe && !mdl_fe_prev) mdl_cnt = 0;
    mdl_fe_prev = fe;
    if (fe && de) begin
      a = {p[3], p[2], p[1], p[0]};
      b = {p[7], p[6], p[5], p[4]};
      exp_beats.push_back(a);
      exp_beats.push_back(b);
      found = 0;
      for (int i = 0; i < 8; i++) begin
        if (!found && p[i] > 16'h0FFF) begin
          found = 1;
          exp_errs.push_back(p[i]);
        end
      end
      if (found && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 1;
    end
  endtask

  // One sensor clock period; called and returns at a negedge of clk_i
  task automatic send_word(input logic [127:0] d, input bit fe, input bit de);
    int hi, lo;
    hi = 3 + $urandom_range(0, 2);
    lo = 3 + $urandom_range(0, 2);
    model_word(d, fe, de);
    eds_sensor_data_i    = d;
    eds_frame_en_i       = fe;
    eds_sensor_data_en_i = de;
    eds_clk_i            = 1'b1;
    repeat (hi) @(negedge clk_i);
    eds_clk_i = 1'b0;
    repeat (lo) @(negedge clk_i);
    check("err_cnt", 64'(eds_error_cnt_o), 64'(mdl_cnt));
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] l7, l6, l5, l4, l3, l2, l1, l0);
    return {l7, l6, l5, l4, l3, l2, l1, l0};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (eds_post_vld_o) begin
        if (exp_beats.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=%h required=none at %0t", eds_post_data_o, $time);
        end else begin
          check("beat_data", eds_post_data_o, exp_beats.pop_front());
        end
      end
      if (eds_error_vld_o) begin
        check("err_with_beat", 64'(eds_post_vld_o), 64'(1));
        if (exp_errs.size() == 0) begin
          checks++; errors++;
          $display("FAIL err_unexpected actual=%h required=none at %0t", eds_error_data_o, $time);
        end else begin
          check("err_data", 64'(eds_error_data_o), 64'(exp_errs.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] base, w;
    logic [15:0]  lv;
    bit           fe, de;
    rst_i = 1'b0;
    eds_clk_i = 1'b0;
    eds_frame_en_i = 1'b0;
    eds_sensor_data_en_i = 1'b0;
    eds_sensor_data_i = '0;
    mdl_cnt = 0;
    mdl_fe_prev = 0;
    repeat (3) @(negedge clk_i);
    check("rst_post_vld",  64'(eds_post_vld_o), 64'(0));
    check("rst_post_data", eds_post_data_o, 64'(0));
    check("rst_err_cnt",   64'(eds_error_cnt_o), 64'(0));
    check("rst_err_vld",   64'(eds_error_vld_o), 64'(0));
    check("rst_err_data",  64'(eds_error_data_o), 64'(0));
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);

    // Single word in natural-order test pattern
    base = lanes(16'h0005, 16'h0002, 16'h0003, 16'h0001, 16'h0008, 16'h0006, 16'h0007, 16'h0004);
    send_word(base, 1, 1);

    // Burst of 256 words, every lane offset by n
    for (int n = 0; n < 256; n++) begin
      w = base;
      for (int k = 0; k < 8; k++) w[16*k +: 16] = w[16*k +: 16] + 16'(n);
      send_word(w, 1, 1);
    end

    // Range error on P1 with P4 also out of range
    send_word(lanes(16'h0005, 16'h0002, 16'h0003, 16'hF001, 16'h0008, 16'h0006, 16'h0007, 16'h1000), 1, 1);

    // Gating by data enable and frame enable
    send_word(lanes(16'h0, 16'h0, 16'h0, 16'hF001, 16'h0, 16'h0, 16'h0, 16'h0), 1, 0);
    send_word(lanes(16'h0, 16'h0, 16'h0, 16'hF001, 16'h0, 16'h0, 16'h0, 16'h0), 0, 1);
    send_word(lanes(16'h0, 16'h0, 16'h0, 16'h0123, 16'h0, 16'h0, 16'h0, 16'h0), 0, 0);

    // Frame restart: counter reaches 3, then a new frame starts at 1
    for (int n = 0; n < 3; n++)
      send_word(lanes(16'h0, 16'h0, 16'h2000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1, 1);
    check("cnt_three", 64'(eds_error_cnt_o), 64'(3));
    send_word(base, 0, 1);
    send_word(lanes(16'h0, 16'h8001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0), 1, 1);
    check("cnt_restart", 64'(eds_error_cnt_o), 64'(1));

    // Reset in the beat-A cycle drops beat B
    w = lanes(16'h0011, 16'h0022, 16'h0033, 16'hA044, 16'h0055, 16'h0066, 16'h0077, 16'h0088);
    model_word(w, 1, 1);
    eds_sensor_data_i = w;
    eds_frame_en_i = 1'b1;
    eds_sensor_data_en_i = 1'b1;
    eds_clk_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    void'(exp_beats.pop_back());
    mdl_cnt = 0;
    mdl_fe_prev = 0;
    #1;
    check("midrst_post_vld",  64'(eds_post_vld_o), 64'(0));
    check("midrst_post_data", eds_post_data_o, 64'(0));
    check("midrst_err_vld",   64'(eds_error_vld_o), 64'(0));
    check("midrst_err_data",  64'(eds_error_data_o), 64'(0));
    check("midrst_err_cnt",   64'(eds_error_cnt_o), 64'(0));
    check("midrst_pending",   64'(exp_beats.size()), 64'(0));
    @(negedge clk_i);
    eds_clk_i = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (4) @(negedge clk_i);
    send_word(base, 1, 1);
    send_word(lanes(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3FFF), 1, 1);

    // Randomized words with random gating and occasional range errors
    for (int n = 0; n < 80; n++) begin
      for (int k = 0; k < 8; k++) w[16*k +: 16] = 16'($urandom_range(0, 16'h0FFF));
      if ($urandom_range(0, 2) == 0) begin
        lv = 16'($urandom_range(1, 15)) << 12;
        w[16*$urandom_range(0, 7) +: 16] |= lv;
      end
      fe = ($urandom_range(0, 4) != 0);
      de = ($urandom_range(0, 3) != 0);
      send_word(w, fe, de);
    end

    repeat (10) @(negedge clk_i);
    check("beats_left", 64'(exp_beats.size()), 64'(0));
    check("errs_left",  64'(exp_errs.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
